// File: rtl/ps2_key_tracker.sv
// Set-2 scancode parser with Shift/Caps tracking feeding a first-word-fall-through key event FIFO.
// Latency: byte strobe at edge t -> modifiers/FSM at t+1, event visible on key_valid at t+1 when FIFO empty.
// Backpressure: bytes never stall; a push into a full FIFO without a same-cycle pop is dropped and sets overflow.

module key_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             pop, full, push_ok;

    always_comb begin
        pop      = (cnt_q != '0) && out_rdy;
        full     = (cnt_q == FULL_CNT);
        // A pop frees the slot in the same cycle, so a full FIFO can still accept.
        push_ok  = in_vld && (!full || pop);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = in_dat;
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        drop_d   = drop_q || (in_vld && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    assign out_vld = (cnt_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign drop    = drop_q;
endmodule

module ps2_key_tracker #(
    parameter int FIFO_DEPTH = 8,
    parameter bit EMIT_BREAK = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make,
    output logic       key_caps,
    output logic       key_shift,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       caps_led,
    output logic       shift_state,
    output logic       overflow
);
    typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK, ST_PAUSE} state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       make;
        logic       caps;
        logic       shift;
    } key_evt_t;

    state_t     state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       caps_led_q, caps_led_d, caps_held_q, caps_held_d;
    logic       code_vld, code_ext, code_make;
    logic       is_prefix, is_noise, is_mod;
    logic       evt_vld;
    key_evt_t   evt_dat, head_dat;

    always_comb begin
        is_prefix = (byte_in == 8'hE0) || (byte_in == 8'hF0) || (byte_in == 8'hE1);
        is_noise  = (byte_in == 8'hAA) || (byte_in == 8'hFA) || (byte_in == 8'hEE) ||
                    (byte_in == 8'hFE) || (byte_in == 8'h00) || (byte_in == 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (byte_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (byte_in == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (byte_in == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (byte_in == 8'hE1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end
                end
                ST_EXT:     state_d = (byte_in == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                ST_PAUSE: begin
                    skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        code_vld  = 1'b0;
        code_ext  = 1'b0;
        code_make = 1'b1;
        if (byte_valid) begin
            unique case (state_q)
                ST_IDLE:    code_vld = !is_prefix && !is_noise;
                ST_EXT: begin
                    code_vld = (byte_in != 8'hF0);
                    code_ext = 1'b1;
                end
                ST_BRK: begin
                    code_vld  = 1'b1;
                    code_make = 1'b0;
                end
                ST_EXT_BRK: begin
                    code_vld  = 1'b1;
                    code_ext  = 1'b1;
                    code_make = 1'b0;
                end
                default:    code_vld = 1'b0;
            endcase
        end
    end

    // E0 12 / E0 59 are fake shifts and fall under is_mod, so they neither move shift nor enqueue.
    always_comb begin
        is_mod      = (byte_in == 8'h12) || (byte_in == 8'h59) || (!code_ext && byte_in == 8'h58);
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        caps_led_d  = caps_led_q;
        caps_held_d = caps_held_q;
        if (code_vld && !code_ext) begin
            if (byte_in == 8'h12) lshift_d = code_make;
            if (byte_in == 8'h59) rshift_d = code_make;
            if (byte_in == 8'h58) begin
                caps_held_d = code_make;
                if (code_make && !caps_held_q) caps_led_d = !caps_led_q;
            end
        end
        evt_vld       = code_vld && !is_mod && (code_make || EMIT_BREAK);
        evt_dat.code  = byte_in;
        evt_dat.ext   = code_ext;
        evt_dat.make  = code_make;
        evt_dat.caps  = caps_led_q;
        evt_dat.shift = lshift_q || rshift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_led_q  <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_led_q  <= caps_led_d;
            caps_held_q <= caps_held_d;
        end
    end

    key_fifo #(
        .WIDTH ($bits(key_evt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (evt_vld),
        .in_dat  (evt_dat),
        .out_vld (key_valid),
        .out_rdy (key_ready),
        .out_dat (head_dat),
        .drop    (overflow)
    );

    assign key_code    = head_dat.code;
    assign key_ext     = head_dat.ext;
    assign key_make    = head_dat.make;
    assign key_caps    = head_dat.caps;
    assign key_shift   = head_dat.shift;
    assign caps_led    = caps_led_q;
    assign shift_state = lshift_q || rshift_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Randomised and directed bench for ps2_key_tracker with a scoreboard fed by a byte-level keyboard model.
module tb_ps2_key_tracker;
    localparam int DEPTH    = 8;
    localparam bit EMIT_BRK = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_make, key_caps, key_shift, key_valid;
    logic       caps_led, shift_state, overflow;

    ps2_key_tracker #(.FIFO_DEPTH(DEPTH), .EMIT_BREAK(EMIT_BRK)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .key_code(key_code), .key_ext(key_ext), .key_make(key_make), .key_caps(key_caps),
        .key_shift(key_shift), .key_valid(key_valid), .key_ready(key_ready),
        .caps_led(caps_led), .shift_state(shift_state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Keyboard model: prefix flags, pause skip count, modifier state, FIFO occupancy.
    bit          m_ext, m_brk, m_lsh, m_rsh, m_caps, m_held, m_ovf, m_pop, m_rst_chk;
    int          m_skip, m_cnt;
    logic [11:0] exp_q[$];

    task automatic model_key(input logic [7:0] b, input bit ext, input bit make);
        if (b == 8'h12 || b == 8'h59) begin
            if (!ext && b == 8'h12) m_lsh = make;
            if (!ext && b == 8'h59) m_rsh = make;
        end else if (!ext && b == 8'h58) begin
            if (make && !m_held) m_caps = !m_caps;
            m_held = make;
        end else if (make || EMIT_BRK) begin
            if (m_cnt < DEPTH || m_pop) begin
                exp_q.push_back({b, ext, make, m_caps, m_lsh | m_rsh});
                m_cnt++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit idle;
        idle = !m_ext && !m_brk;
        if (m_skip > 0) begin
            m_skip--;
        end else if (idle && b == 8'hE1) begin
            m_skip = 7;
        end else if (idle && b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (!m_brk && b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (idle && (b == 8'hAA || b == 8'hFA || b == 8'hEE ||
                              b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
            // line noise / controller responses
        end else begin
            model_key(b, m_ext, !m_brk);
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_ext = 0; m_brk = 0; m_skip = 0; m_lsh = 0; m_rsh = 0;
            m_caps = 0; m_held = 0; m_ovf = 0; m_cnt = 0; m_rst_chk = 1;
            exp_q.delete();
        end else begin
            m_pop = (m_cnt > 0) && key_ready;
            if (byte_valid) model_byte(byte_in);
            if (m_pop) m_cnt--;
        end
    end

    // Monitor: compares live state every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (m_rst_chk) begin
            check("reset_payload", {20'd0, key_code, key_ext, key_make, key_caps, key_shift}, 32'd0);
            m_rst_chk = 0;
        end
        check("status{valid,caps,shift,ovf}", {28'd0, key_valid, caps_led, shift_state, overflow},
              {28'd0, m_cnt > 0, m_caps, m_lsh | m_rsh, m_ovf});
        if (key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: got code %0h, expected no event", key_code);
            end else begin
                check("event{code,ext,make,caps,shift}",
                      {20'd0, key_code, key_ext, key_make, key_caps, key_shift},
                      {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [7:0] b, input logic rdy);
        @(posedge clk);
        #1;
        reset      = rst;
        byte_valid = v;
        byte_in    = b;
        key_ready  = rdy;
    endtask

    task automatic send(input logic [7:0] b, input logic rdy);
        drive(1'b0, 1'b1, b, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, rdy);
    endtask

    logic [7:0] pool [12] = '{8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'hE1,
                              8'h1C, 8'h15, 8'h75, 8'hAA, 8'hFF, 8'h3A};

    initial begin
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        idle(2, 1'b1);

        send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1); idle(4, 1);
        send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h12, 1); send(8'h1C, 1); idle(4, 1);
        send(8'h58, 1); send(8'h58, 1); send(8'h58, 1); send(8'hF0, 1); send(8'h58, 1);
        send(8'h58, 1); send(8'hF0, 1); send(8'h58, 1); idle(3, 1);
        send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        send(8'hE0, 1); send(8'h12, 1); send(8'hE1, 1); send(8'h14, 1); send(8'h77, 1);
        send(8'hE1, 1); send(8'hF0, 1); send(8'h14, 1); send(8'hF0, 1); send(8'h77, 1);
        send(8'h1C, 1); idle(4, 1);

        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 0);
        idle(2, 0);
        send(8'h1E, 1);
        idle(12, 1);

        send(8'hE0, 1);
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        send(8'h75, 1);
        idle(4, 1);

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            if ($urandom_range(0, 399) == 0)
                drive(1'b1, 1'b0, 8'h00, 1'b0);
            else
                drive(1'b0, $urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 6);
        end

        idle(2 * DEPTH + 4, 1);
        check("drain_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Sits between the PS/2 byte receiver and the scancode-to-ASCII lookup. Consumes raw Set-2 scancode bytes, strips make/break/extended prefixes, and tracks Shift and Caps Lock state. Emits clean key events, each carrying the scancode plus a snapshot of the caps and shift flags, through a small FIFO with a valid/ready handshake. The lookup's address, caps and shift inputs are driven directly from the FIFO head.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2
- EMIT_BREAK, 0, 1 = also enqueue break events for non-modifier keys
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; dominates all other inputs
- byte_in  in  8  received scancode byte
- byte_valid  in  1  one-cycle strobe; byte_in valid this cycle
- key_code  out  8  scancode at FIFO head
- key_ext  out  1  head event was E0-prefixed
- key_make  out  1  1 = make, 0 = break (always 1 when EMIT_BREAK=0)
- key_caps  out  1  caps-lock state snapshot at enqueue
- key_shift  out  1  shift state snapshot at enqueue (left OR right)
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer pops head when key_valid & key_ready
- caps_led  out  1  live caps-lock toggle state
- shift_state  out  1  live left-shift OR right-shift held
- overflow  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- Parser FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), PAUSE (discarding)
- IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip counter = 7; AA/FA/EE/FE/00/FF are discarded and the FSM stays in IDLE; any other byte is a make code, processed, then IDLE
- EXT: F0 -> EXT_BRK; any other byte is an extended make, processed, then IDLE
- BRK / EXT_BRK: byte is a break code (extended in EXT_BRK), processed, then IDLE
- PAUSE: each byte decrements the counter; when it reaches 0, return to IDLE; no events
- Modifiers (non-extended only): 12 = left shift, 59 = right shift, 58 = caps lock
- Shift make sets its held bit; shift break clears it. No event is enqueued.
- Extended 12/59 (E0 12 fake-shift) are ignored entirely
- Caps make toggles caps_led only if caps_held=0, then sets caps_held. Caps break clears caps_held. Typematic repeat therefore does not re-toggle. No event is enqueued.
- Non-modifier make: enqueue {code, ext, make=1, caps_led, shift_state} using values before this byte is applied. Typematic repeats enqueue every time.
- Non-modifier break: enqueue with make=0 only when EMIT_BREAK=1; otherwise discard
- FIFO: head is registered, first-word-fall-through. A push when full is dropped and sets overflow, unless a pop occurs in the same cycle, in which case the push is accepted. A simultaneous push and pop on an empty FIFO is impossible, because valid is 0.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits

## Timing
- Reset values: FSM=IDLE, skip counter=0, caps_led=0, caps_held=0, both shift bits=0, FIFO empty, key_valid=0, overflow=0. key_code/key_ext/key_make/key_caps/key_shift=0.
- Reset asserted mid-sequence (e.g. after E0 or inside PAUSE) aborts the sequence. The next byte is parsed from IDLE.
- byte_valid at edge t: FSM, caps_led and shift_state update at t+1
- Event enqueued at t appears on key_valid at t+1 if the FIFO was empty (1-cycle latency)
- Pop at t: the next entry is on the outputs at t+1; key_valid drops at t+1 if the FIFO is now empty
- byte_valid strobes may arrive on consecutive cycles; every byte is processed, with no stall
- Outputs hold their values while key_valid & !key_ready

## Test plan
- Reset, then bytes 1C, F0 1C with key_ready=1: one event code=1C, make=1, caps=0, shift=0, ext=0; key_valid high for exactly 1 cycle
- 12, 1C, F0 12, 1C: events 1C with shift=1, then 1C with shift=0; shift_state high between 12 and F0 12
- 58, 58, 58, F0 58, 58, F0 58 (repeat then release twice): caps_led goes 1 after the first 58, stays 1 through the repeats, then 0 after the second press; no events
- E0 75, E0 F0 75, E0 12, E1 14 77 E1 F0 14 F0 77, 1C: exactly two events, 75 ext=1 then 1C; shift_state stays 0
- key_ready=0, FIFO_DEPTH=8, nine makes 15..1D: the first eight are held in order, overflow=1, 1D is lost. Then key_ready=1 with push and pop on the same full cycle: the push is accepted.
- Reset asserted between E0 and 75: the following 75 is enqueued with ext=0, and all outputs match the reset values in the cycle after reset
